// File: rtl/store_trace_fifo_pkg.sv
// Shared types for the RV32I store trace path.
// Build option: STORE_TRACE_FILTER_EN (address filter in store_trace_fifo).
package risc_v_trace_pkg;

  localparam int SEQ_W = 16;
  localparam int OVF_W = 16;

  // One captured store as held in the FIFO.
  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } trace_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/store_trace_fifo_if.sv
// Store capture inputs and trace output stream of store_trace_fifo.
// master: the trace buffer itself; slave: the core/consumer side.
// Build option: STORE_TRACE_FILTER_EN (affects the design, not this bundle).
interface store_trace_fifo_if
  import risc_v_trace_pkg::*;
#(
  parameter int DEPTH = 8
) ();

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             store_en;
  logic [31:0]      store_addr;
  logic [31:0]      store_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [SEQ_W-1:0] out_seq;
  logic [LVL_W-1:0] level;
  logic [OVF_W-1:0] overflow_count;

  modport master (
    input  store_en, store_addr, store_data, out_ready,
    output out_valid, out_addr, out_data, out_seq, level, overflow_count
  );

  modport slave (
    output store_en, store_addr, store_data, out_ready,
    input  out_valid, out_addr, out_data, out_seq, level, overflow_count
  );

endinterface

// File: rtl/store_trace_fifo_trace_fifo.sv
// Generic first-word-fall-through FIFO of trace entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Build option: STORE_TRACE_FILTER_EN has no effect here.
module trace_fifo
  import risc_v_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  trace_entry_t           wr_entry,
  input  logic                   pop,
  output trace_entry_t           rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  trace_entry_t mem_reg [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Wrap-bit arithmetic makes the difference the occupancy directly.
  assign level = wr_ptr_reg - rd_ptr_reg;

  // Head is presented combinationally; fields read zero while empty.
  assign rd_entry = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

  // Pointer update on accepted push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/store_trace_fifo.sv
// Captures core store transactions into a trace FIFO with sequence numbers
// and a saturating drop counter. The core never stalls: stores that find
// the FIFO full (with no pop in the same cycle) are dropped and counted.
// Build option: STORE_TRACE_FILTER_EN -- only stores to the word at
// MATCH_ADDR are captured; otherwise every store_en cycle is captured.
module store_trace_fifo
  import risc_v_trace_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] MATCH_ADDR = 32'd100
) (
  input  logic               clk,
  input  logic               reset,
  store_trace_fifo_if.master bus
);

  logic                   qualify;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [SEQ_W-1:0]       seq_reg;
  logic [OVF_W-1:0]       ovf_reg;
  trace_entry_t           wr_entry;
  trace_entry_t           rd_entry;

`ifdef STORE_TRACE_FILTER_EN
  assign qualify = bus.store_en && (bus.store_addr[31:2] == MATCH_ADDR[31:2]);
`else
  logic match_addr_unused;
  assign match_addr_unused = ^MATCH_ADDR;
  assign qualify = bus.store_en;
`endif

  assign pop  = bus.out_ready && !fifo_empty;
  assign drop = qualify && fifo_full && !pop;

  // Entry carries the sequence count before this store's increment.
  assign wr_entry = '{addr: bus.store_addr, data: bus.store_data, seq: seq_reg};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (qualify),
    .wr_entry (wr_entry),
    .pop      (pop),
    .rd_entry (rd_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Sequence advances on every qualifying store, dropped or not, so the
  // consumer sees a gap whenever something was lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_reg <= '0;
    end else if (qualify) begin
      seq_reg <= seq_reg + 1'b1;
    end
  end

  // Drop counter holds at all-ones once saturated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= '0;
    end else if (drop) begin
      ovf_reg <= sat_inc(ovf_reg);
    end
  end

  assign bus.out_valid      = !fifo_empty;
  assign bus.out_addr       = rd_entry.addr;
  assign bus.out_data       = rd_entry.data;
  assign bus.out_seq        = rd_entry.seq;
  assign bus.level          = fifo_level;
  assign bus.overflow_count = ovf_reg;

endmodule

// File: tb/tb_store_trace_fifo.sv
// Self-checking bench for store_trace_fifo: directed test-plan steps plus a
// randomized phase, all checked against a queue-based reference model.
// Honours STORE_TRACE_FILTER_EN when the design is built with it.
module tb_store_trace_fifo;

  localparam int          DEPTH      = 8;
  localparam logic [31:0] MATCH_ADDR = 32'd100;

  logic clk = 1'b0;
  logic reset;

  store_trace_fifo_if #(.DEPTH(DEPTH)) bus ();

  store_trace_fifo #(
    .DEPTH      (DEPTH),
    .MATCH_ADDR (MATCH_ADDR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] seq;
  } ref_t;

  ref_t        q[$];
  int unsigned m_seq;
  int unsigned m_ovf;
  int          tests_run = 0;
  int          failed    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit qualifies(input logic en, input logic [31:0] addr);
`ifdef STORE_TRACE_FILTER_EN
    return en && (addr[31:2] == MATCH_ADDR[31:2]);
`else
    return en && (addr == addr);
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_seq = 0;
    m_ovf = 0;
  endtask

  task automatic drive(input logic en, input logic [31:0] addr,
                       input logic [31:0] data, input logic ready);
    bus.store_en   = en;
    bus.store_addr = addr;
    bus.store_data = data;
    bus.out_ready  = ready;
  endtask

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic cycle();
    int   n;
    bit   do_pop;
    bit   do_push;
    ref_t e;
    n       = q.size();
    do_pop  = bus.out_ready && (n > 0);
    do_push = 1'b0;
    if (qualifies(bus.store_en, bus.store_addr)) begin
      if (n < DEPTH || do_pop) begin
        do_push = 1'b1;
        e.addr  = bus.store_addr;
        e.data  = bus.store_data;
        e.seq   = m_seq[15:0];
      end else if (m_ovf < 32'hFFFF) begin
        m_ovf++;
      end
      m_seq = (m_seq + 1) & 32'hFFFF;
    end
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    ref_t h;
    bit   ne;
    ne = (q.size() > 0);
    if (ne) h = q[0];
    else begin
      h.addr = '0; h.data = '0; h.seq = '0;
    end
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(ne));
    chk({tag, ".level"}, 64'(bus.level), 64'(q.size()));
    chk({tag, ".ovf"},   64'(bus.overflow_count), 64'(m_ovf));
    chk({tag, ".addr"},  64'(bus.out_addr), 64'(h.addr));
    chk({tag, ".data"},  64'(bus.out_data), 64'(h.data));
    chk({tag, ".seq"},   64'(bus.out_seq), 64'(h.seq));
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;

    // Reset state
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    #3;
    check_all("reset");
    chk("reset.valid_const", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Single store, then pop it
    drive(1'b1, 32'h64, 32'hDEADBEEF, 1'b0);
    cycle();
    check_all("single");
    chk("single.addr_const", 64'(bus.out_addr), 64'h64);
    chk("single.data_const", 64'(bus.out_data), 64'hDEADBEEF);
    chk("single.seq_const", 64'(bus.out_seq), 64'd0);
    chk("single.level_const", 64'(bus.level), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    check_all("single_pop");
    chk("single_pop.level_const", 64'(bus.level), 64'd0);

    // Burst of 10 into an 8-deep FIFO, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, MATCH_ADDR, 32'(i), 1'b0);
      cycle();
      check_all("burst");
    end
    chk("burst.level_const", 64'(bus.level), 64'd8);
    chk("burst.ovf_const", 64'(bus.overflow_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      chk("drain.seq_const", 64'(bus.out_seq), 64'(i));
      chk("drain.data_const", 64'(bus.out_data), 64'(i));
      cycle();
      check_all("drain");
    end

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, MATCH_ADDR, 32'h10 + 32'(i), 1'b0);
      cycle();
    end
    check_all("fill");
    drive(1'b1, MATCH_ADDR, 32'hA5, 1'b1);
    cycle();
    check_all("fullpp");
    chk("fullpp.level_const", 64'(bus.level), 64'd8);
    chk("fullpp.ovf_const", 64'(bus.overflow_count), 64'd2);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      cycle();
      check_all("fullpp_drain");
    end
    chk("fullpp.a5_head", 64'(bus.out_data), 64'hA5);
    cycle();
    check_all("fullpp_empty");

    // Overflow saturation and seq wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, MATCH_ADDR, 32'(i), 1'b0);
      cycle();
    end
    for (int i = 0; i < 32'h10005; i++) begin
      drive(1'b1, MATCH_ADDR, 32'hFF, 1'b0);
      cycle();
    end
    check_all("sat");
    chk("sat.ovf_const", 64'(bus.overflow_count), 64'hFFFF);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();
    drive(1'b1, MATCH_ADDR, 32'h77, 1'b0);
    cycle();
    check_all("sat_push");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      if (i == 7) begin
        chk("wrap.data_const", 64'(bus.out_data), 64'h77);
        chk("wrap.seq_const", 64'(bus.out_seq), 64'h000D);
      end
      cycle();
      check_all("sat_drain");
    end

    // Asynchronous reset with entries queued
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, MATCH_ADDR, 32'h200 + 32'(i), 1'b0);
      cycle();
    end
    check_all("pre_areset");
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    chk("areset.ovf_const", 64'(bus.overflow_count), 64'd0);
    chk("areset.level_const", 64'(bus.level), 64'd0);
    #2;
    reset = 1'b0;
    drive(1'b1, MATCH_ADDR, 32'h300, 1'b0);
    cycle();
    check_all("post_areset");
    chk("post_areset.seq_const", 64'(bus.out_seq), 64'd0);

    // Address filter
    do_reset();
    drive(1'b1, 32'h60, 32'h1, 1'b0); cycle();
    drive(1'b1, 32'h64, 32'h2, 1'b0); cycle();
    drive(1'b1, 32'h67, 32'h3, 1'b0); cycle();
    check_all("filter");
`ifdef STORE_TRACE_FILTER_EN
    chk("filter.level_const", 64'(bus.level), 64'd2);
    chk("filter.head_addr", 64'(bus.out_addr), 64'h64);
`else
    chk("filter.level_const", 64'(bus.level), 64'd3);
    chk("filter.head_addr", 64'(bus.out_addr), 64'h60);
`endif
    chk("filter.head_seq", 64'(bus.out_seq), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) ra = {MATCH_ADDR[31:2], 2'($urandom_range(0, 3))};
      else          ra = $urandom;
      drive(1'(($urandom_range(0, 9)) < 7), ra, $urandom,
            1'(($urandom_range(0, 9)) < 4));
      cycle();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
